lag_energy_acc: RTL and testbench
=================================

Name: lag_energy_acc

Overview:
Computes the 32-bit saturated signal energy for the open-loop pitch search, using the G.729 operation t0 = L_mac(t0, x[i], x[i]) over N consecutive samples stored in scratch memory. The block sits directly upstream of the inverse-square-root stage. It writes the energy word to a scratch address, and the controller then passes that address to the inverse-square-root stage as its L_x input. Arithmetic is done by the shared external L_mac unit. The block only sequences operands, memory reads and the final memory write.

Parameters:
ADDR_W, 11, width of scratch memory addresses; all address arithmetic wraps modulo 2^ADDR_W.
LEN_W, 8, width of the sample-count input; maximum N = 2^LEN_W - 1.

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high; forces state INIT and clears all internal registers
start  in  1  one-cycle (or held) request; sampled only in INIT
xAddr  in  ADDR_W  address of x[0]; sample i is at xAddr+i, and the sample is memIn[15:0] (upper bits ignored)
len  in  LEN_W  number of samples N; latched at start
outAddr  in  ADDR_W  destination address of the energy word; latched at start
L_macIn  in  32  result from the shared L_mac unit
memIn  in  32  scratch read data; valid in the cycle after memReadAddr is driven
L_macOutA  out  16  L_mac operand a
L_macOutB  out  16  L_mac operand b
L_macOutC  out  32  L_mac accumulator operand
memReadAddr  out  ADDR_W  scratch read address
memWriteAddr  out  ADDR_W  scratch write address
memOut  out  32  scratch write data
memWriteEn  out  1  scratch write strobe
done  out  1  one-cycle completion pulse

Behaviour:
- Output style:
  - All outputs are combinational decodes of the current state and registers.
  - Every output is 0 in any cycle that does not explicitly drive it, including during reset.
- Internal registers: state, acc[31:0], cnt[LEN_W-1:0], base, N, dst. All are cleared to 0 by reset.
- INIT:
  - If start=0: remain in INIT.
  - If start=1: latch base=xAddr, N=len, dst=outAddr; clear acc and cnt; drive memReadAddr=xAddr.
  - Next state is RUN if len!=0, else WRITE.
- RUN (one sample per cycle):
  - Drive L_macOutA = L_macOutB = memIn[15:0] and L_macOutC = acc.
  - Load acc <= L_macIn and cnt <= cnt+1.
  - Drive memReadAddr = base+cnt+1, which prefetches the next sample.
  - When cnt == N-1, the next state is WRITE; otherwise stay in RUN.
- WRITE:
  - Drive memWriteAddr=dst, memOut=acc, memWriteEn=1, done=1.
  - Next state is INIT.
- L_mac semantics (supplied externally; the bench model must match):
  - L_mult(a,b) = sat32(2*a*b).
  - 0x8000*0x8000 yields 0x7FFFFFFF.
  - The add is saturating at 0x7FFFFFFF / 0x80000000.
- Result properties: the result is always >= 0 and saturates at 0x7FFFFFFF. Once saturated it stays there, because every further term is >= 0.
- Latency: start (INIT cycle) to done/write is N+1 cycles; exactly one memory write per job.
- N=0: the write of 0x00000000 to outAddr occurs in the cycle after start, with done. The downstream stage then returns 0x3FFFFFFF for this input.
- Boundary and concurrency rules:
  - start is ignored outside INIT; no queueing.
  - A start asserted in the same cycle as done is not seen until INIT.
  - len, xAddr and outAddr may change after the start cycle without effect.
  - Address wrap: base+cnt+1 past 2^ADDR_W-1 wraps to 0.
  - Reset mid-operation: the next cycle is INIT with all outputs 0, no write and no done pulse; partial results are discarded.
  - outAddr may equal a sample address. The write happens after the final read, so it is safe.

Test Plan:
- Basic sum: x=[1,2,3,4] at xAddr=0x100, len=4, outAddr=0x200 -> mem[0x200]=0x0000003C; done exactly 5 cycles after the start cycle; exactly one write.
- Signed samples: x=[0xFFFD,0x0005], len=2 -> 2*(9+25) = 0x00000044.
- Saturation: x=[0x8000,0x0001,0x7FFF], len=3 -> 0x7FFFFFFF, with acc holding 0x7FFFFFFF from the first RUN cycle onward. Separately, 80 samples of 0x7FFF -> 0x7FFFFFFF.
- Zero length: len=0, outAddr=0x010 -> the cycle after start drives memWriteAddr=0x010, memOut=0, memWriteEn=1, done=1. No memReadAddr changes after the start cycle.
- Reset and protocol:
  - reset asserted in the 3rd RUN cycle of a len=10 job -> no write and no done.
  - A new job (x=[2], len=1) then yields 0x00000008.
  - A start pulsed during RUN is ignored.
- Address wrap: xAddr=0x7FE, len=4 -> reads at 0x7FE, 0x7FF, 0x000, 0x001 in consecutive cycles; sum matches the reference model.

Source files
------------

// File: rtl/lag_energy_acc.sv
`default_nettype none
// ============================================================================
// Module   : lag_energy_acc
// Summary  : Sequences a saturated sum-of-squares (L_mac) over N scratch
//            samples and writes the 32-bit energy word back to scratch memory.
// Revision : 1.0
// ============================================================================
module lag_energy_acc #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] xAddr,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] outAddr,
  input  logic [31:0]       L_macIn,
  input  logic [31:0]       memIn,
  output logic [15:0]       L_macOutA,
  output logic [15:0]       L_macOutB,
  output logic [31:0]       L_macOutC,
  output logic [ADDR_W-1:0] memReadAddr,
  output logic [ADDR_W-1:0] memWriteAddr,
  output logic [31:0]       memOut,
  output logic              memWriteEn,
  output logic              done
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [31:0]       r_acc;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_n;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_dst;

  logic              w_lastSample;
  logic [ADDR_W-1:0] w_prefetchAddr;
  logic              w_unusedMemHi;

  assign w_lastSample   = (r_cnt == (r_n - LEN_W'(1)));
  assign w_prefetchAddr = r_base + ADDR_W'(r_cnt) + ADDR_W'(1);
  // Samples live in the low half-word only.
  assign w_unusedMemHi  = ^memIn[31:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_base  <= '0;
      r_dst   <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_INIT: begin
          if (start) begin
            r_base <= xAddr;
            r_n    <= len;
            r_dst  <= outAddr;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_acc <= L_macIn;
          r_cnt <= r_cnt + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState  = r_state;
    L_macOutA    = '0;
    L_macOutB    = '0;
    L_macOutC    = '0;
    memReadAddr  = '0;
    memWriteAddr = '0;
    memOut       = '0;
    memWriteEn   = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_INIT: begin
        if (start) begin
          memReadAddr = xAddr;
          w_nextState = (len != '0) ? S_RUN : S_WRITE;
        end
      end
      S_RUN: begin
        L_macOutA   = memIn[15:0];
        L_macOutB   = memIn[15:0];
        L_macOutC   = r_acc;
        memReadAddr = w_prefetchAddr;
        if (w_lastSample) begin
          w_nextState = S_WRITE;
        end
      end
      S_WRITE: begin
        memWriteAddr = r_dst;
        memOut       = r_acc;
        memWriteEn   = 1'b1;
        done         = 1'b1;
        w_nextState  = S_INIT;
      end
      default: w_nextState = S_INIT;
    endcase
    // Outputs are held quiet for the whole reset cycle, whatever the state.
    if (reset) begin
      L_macOutA    = '0;
      L_macOutB    = '0;
      L_macOutC    = '0;
      memReadAddr  = '0;
      memWriteAddr = '0;
      memOut       = '0;
      memWriteEn   = 1'b0;
      done         = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lag_energy_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_lag_energy_acc
// Summary  : Directed self-checking bench for lag_energy_acc with a scratch
//            memory and L_mac reference unit.
// Revision : 1.0
// ============================================================================
module tb_lag_energy_acc;

  localparam int ADDR_W = 11;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] xAddr;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] outAddr;
  logic [31:0]       L_macIn;
  logic [31:0]       memIn;
  logic [15:0]       L_macOutA;
  logic [15:0]       L_macOutB;
  logic [31:0]       L_macOutC;
  logic [ADDR_W-1:0] memReadAddr;
  logic [ADDR_W-1:0] memWriteAddr;
  logic [31:0]       memOut;
  logic              memWriteEn;
  logic              done;

  lag_energy_acc #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .xAddr        (xAddr),
    .len          (len),
    .outAddr      (outAddr),
    .L_macIn      (L_macIn),
    .memIn        (memIn),
    .L_macOutA    (L_macOutA),
    .L_macOutB    (L_macOutB),
    .L_macOutC    (L_macOutC),
    .memReadAddr  (memReadAddr),
    .memWriteAddr (memWriteAddr),
    .memOut       (memOut),
    .memWriteEn   (memWriteEn),
    .done         (done)
  );

  always #5 clk = ~clk;

  // External L_mac unit: sat32(c + sat32(2*a*b)).
  function automatic logic [31:0] lmac(input logic [31:0] c, input logic [15:0] a,
                                       input logic [15:0] b);
    longint p;
    longint s;
    p = 2 * longint'($signed(a)) * longint'($signed(b));
    if (p > 64'sh7FFFFFFF) p = 64'sh7FFFFFFF;
    s = longint'($signed(c)) + p;
    if (s > 64'sh7FFFFFFF) s = 64'sh7FFFFFFF;
    if (s < -64'sh80000000) s = -64'sh80000000;
    return s[31:0];
  endfunction

  assign L_macIn = lmac(L_macOutC, L_macOutA, L_macOutB);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int          writeCount = 0;
  int          doneCount  = 0;

  always @(posedge clk) begin
    memIn <= mem[memReadAddr];
    if (memWriteEn) begin
      mem[memWriteAddr] <= memOut;
      writeCount++;
    end
    if (done) doneCount++;
  end

  int nChecks = 0;
  int nPassed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPassed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  logic [ADDR_W-1:0] rAddr [0:400];
  logic [31:0]       cAcc  [0:400];
  logic [ADDR_W-1:0] gotWAddr;
  logic [31:0]       gotWData;
  logic              gotWEn;

  // Launches one job, traces it until done (bounded), then checks
  // latency, the single write and the stored energy word.
  task automatic runJob(input string tag, input logic [ADDR_W-1:0] xa,
                        input logic [LEN_W-1:0] n, input logic [ADDR_W-1:0] oa,
                        input logic [31:0] expVal, input int pulseAt);
    int  w0;
    int  k;
    bit  seen;
    w0 = writeCount;
    @(negedge clk);
    start = 1'b1; xAddr = xa; len = n; outAddr = oa;
    #1 rAddr[0] = memReadAddr;
    k = 0; seen = 0;
    while (!seen && k < 400) begin
      @(negedge clk);
      k++;
      start   = (k == pulseAt);
      xAddr   = (k == pulseAt) ? 11'h7F0 : ~xa;
      outAddr = (k == pulseAt) ? 11'h7F0 : ~oa;
      len     = 8'd1;
      #1;
      rAddr[k] = memReadAddr;
      cAcc[k]  = L_macOutC;
      if (done) begin
        seen     = 1;
        gotWAddr = memWriteAddr;
        gotWData = memOut;
        gotWEn   = memWriteEn;
      end
    end
    start = 1'b0;
    chk($sformatf("%s_latency", tag), k, 32'(n) + 1);
    @(posedge clk); #1;
    chk($sformatf("%s_result", tag), mem[oa], expVal);
    chk($sformatf("%s_writes", tag), writeCount - w0, 1);
  endtask

  initial begin
    int w0;
    int d0;
    reset = 1'b1; start = 1'b0; xAddr = '0; len = '0; outAddr = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_wen",   32'(memWriteEn), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_raddr", 32'(memReadAddr), 0);
    chk("rst_macC",  L_macOutC, 0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("idle_outs", {L_macOutA, 5'd0, memWriteAddr}, 0);

    // Basic sum; upper memory bits are junk and must be ignored.
    mem[11'h100] = 32'hABCD0001; mem[11'h101] = 32'h00000002;
    mem[11'h102] = 32'h55550003; mem[11'h103] = 32'h00000004;
    runJob("basic", 11'h100, 8'd4, 11'h200, 32'h0000003C, 0);
    chk("basic_raddr0", 32'(rAddr[0]), 32'h100);

    // Signed samples: 2*(9+25).
    mem[11'h120] = 32'h0000FFFD; mem[11'h121] = 32'h00000005;
    runJob("signed", 11'h120, 8'd2, 11'h210, 32'h00000044, 0);

    // Saturation from 0x8000*0x8000 in the first term.
    mem[11'h130] = 32'h00008000; mem[11'h131] = 32'h00000001; mem[11'h132] = 32'h00007FFF;
    runJob("sat3", 11'h130, 8'd3, 11'h220, 32'h7FFFFFFF, 0);
    chk("sat3_acc_run2", cAcc[2], 32'h7FFFFFFF);
    chk("sat3_acc_run3", cAcc[3], 32'h7FFFFFFF);

    for (int i = 0; i < 80; i++) mem[11'h300 + i] = 32'h00007FFF;
    runJob("sat80", 11'h300, 8'd80, 11'h230, 32'h7FFFFFFF, 0);

    // Zero length: write of 0 right after the start cycle.
    mem[11'h010] = 32'hDEADBEEF;
    runJob("zero", 11'h140, 8'd0, 11'h010, 32'h00000000, 0);
    chk("zero_waddr", 32'(gotWAddr), 32'h010);
    chk("zero_wdata", gotWData, 0);
    chk("zero_wen",   32'(gotWEn), 1);
    chk("zero_raddr1", 32'(rAddr[1]), 0);

    // Reset in the 3rd RUN cycle of a len=10 job.
    for (int i = 0; i < 10; i++) mem[11'h400 + i] = 32'h00000003;
    mem[11'h240] = 32'h12345678;
    w0 = writeCount; d0 = doneCount;
    @(negedge clk);
    start = 1'b1; xAddr = 11'h400; len = 8'd10; outAddr = 11'h240;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("midrst_outs", {L_macOutC[15:0], 5'd0, memReadAddr}, 0);
    @(negedge clk); reset = 1'b0;
    #1 chk("midrst_after_macC", L_macOutC, 0);
    repeat (20) @(negedge clk);
    chk("midrst_nowrite", writeCount - w0, 0);
    chk("midrst_nodone",  doneCount - d0, 0);
    chk("midrst_mem",     mem[11'h240], 32'h12345678);

    mem[11'h410] = 32'h00000002;
    runJob("after_rst", 11'h410, 8'd1, 11'h250, 32'h00000008, 0);

    // Start pulsed mid-RUN must be ignored.
    runJob("pulse", 11'h100, 8'd4, 11'h260, 32'h0000003C, 2);
    repeat (8) @(negedge clk);
    chk("pulse_nowrite7F0", mem[11'h7F0], 0);

    // Address wrap: 2*(9+1+100+65536).
    mem[11'h7FE] = 32'h00000003; mem[11'h7FF] = 32'h0000FFFF;
    mem[11'h000] = 32'h0000000A; mem[11'h001] = 32'h00000100;
    runJob("wrap", 11'h7FE, 8'd4, 11'h270, 32'h000200DC, 0);
    chk("wrap_rd0", 32'(rAddr[0]), 32'h7FE);
    chk("wrap_rd1", 32'(rAddr[1]), 32'h7FF);
    chk("wrap_rd2", 32'(rAddr[2]), 32'h000);
    chk("wrap_rd3", 32'(rAddr[3]), 32'h001);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
